// File: rtl/mc14500_seq_core_if.sv
// Program-ROM bus between the MC14500 sequential core (master) and a synchronous ROM (slave).
interface mc14500_seq_core_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [ADDR_WIDTH+3:0] prog_data;

    modport master (output prog_addr, input prog_data);
    modport slave  (input prog_addr, output prog_data);
endinterface

// File: rtl/mc14500_seq_core.sv
// Single-clock MC14500B-compatible sequencer: 2-cycle fetch/execute over a synchronous
// program ROM, with return stack, SKZ/RTN skipping and memory-mapped I/O and scratch bits.
module mc14500_seq_core #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned INPUT_SIZE   = 5,
    parameter int unsigned OUTPUT_SIZE  = 5,
    parameter int unsigned SCRATCH_SIZE = 16,
    parameter int unsigned STACK_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    mc14500_seq_core_if.master     prog,
    input  logic [INPUT_SIZE-1:0]  input_pins,
    output logic [OUTPUT_SIZE-1:0] output_pins,
    output logic                   flag_o,
    output logic                   flag_f,
    output logic                   jmp_o,
    output logic                   rtn_o,
    output logic                   stack_err,
    output logic                   rr_out
);

    localparam int unsigned OUT_BASE = INPUT_SIZE;
    localparam int unsigned SCR_BASE = INPUT_SIZE + OUTPUT_SIZE;
    localparam int unsigned SPW      = $clog2(STACK_DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    logic [1:0]              state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic                    rr, ien, oen, skip;
    logic [SPW-1:0]          sp;
    // Sized to the full SP range so SP indexes it without truncation; only STACK_DEPTH entries are used.
    logic [ADDR_WIDTH-1:0]   stack [2**SPW];
    logic [INPUT_SIZE-1:0]   sync1, sync2;
    logic [OUTPUT_SIZE-1:0]  out_latch;
    logic [SCRATCH_SIZE-1:0] scratch;

    logic [3:0]              opcode;
    logic [ADDR_WIDTH-1:0]   iaddr;
    logic                    d, di, rr_n, wval, do_store;

    assign opcode      = prog.prog_data[ADDR_WIDTH+3:ADDR_WIDTH];
    assign iaddr       = prog.prog_data[ADDR_WIDTH-1:0];
    assign pc_inc      = pc + ADDR_WIDTH'(1);
    assign prog.prog_addr = pc;
    assign output_pins = out_latch;
    assign rr_out      = rr;

    always_comb begin
        d = 1'b0;
        for (int unsigned i = 0; i < INPUT_SIZE; i++)
            if (iaddr == ADDR_WIDTH'(i)) d = sync2[i];
        for (int unsigned i = 0; i < OUTPUT_SIZE; i++)
            if (iaddr == ADDR_WIDTH'(OUT_BASE + i)) d = out_latch[i];
        for (int unsigned i = 0; i < SCRATCH_SIZE; i++)
            if (iaddr == ADDR_WIDTH'(SCR_BASE + i)) d = scratch[i];
        if (iaddr == '1) d = rr;
    end

    assign di       = d & ien;
    assign wval     = (opcode == OP_STOC) ? ~rr : rr;
    assign do_store = oen && (opcode == OP_STO || opcode == OP_STOC);

    always_comb begin
        rr_n = rr;
        case (opcode)
            OP_LD:   rr_n = di;
            OP_LDC:  rr_n = ~di;
            OP_AND:  rr_n = rr & di;
            OP_ANDC: rr_n = rr & ~di;
            OP_OR:   rr_n = rr | di;
            OP_ORC:  rr_n = rr | ~di;
            OP_XNOR: rr_n = ~(rr ^ di);
            OP_STO, OP_STOC: if (do_store && iaddr == '1) rr_n = wval;
            default: rr_n = rr;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= input_pins;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pc        <= '0;
            rr        <= 1'b0;
            ien       <= 1'b1;
            oen       <= 1'b1;
            skip      <= 1'b0;
            sp        <= '0;
            out_latch <= '0;
            scratch   <= '0;
            stack_err <= 1'b0;
            flag_o    <= 1'b0;
            flag_f    <= 1'b0;
            jmp_o     <= 1'b0;
            rtn_o     <= 1'b0;
            for (int unsigned i = 0; i < 2**SPW; i++) stack[i] <= '0;
        end else begin
            flag_o <= 1'b0;
            flag_f <= 1'b0;
            jmp_o  <= 1'b0;
            rtn_o  <= 1'b0;
            case (state)
                IDLE:  if (run) state <= FETCH;
                FETCH: state <= EXEC;
                EXEC: begin
                    state <= run ? FETCH : IDLE;
                    pc    <= pc_inc;
                    if (skip) begin
                        skip <= 1'b0;
                    end else begin
                        rr <= rr_n;
                        for (int unsigned i = 0; i < OUTPUT_SIZE; i++)
                            if (do_store && iaddr == ADDR_WIDTH'(OUT_BASE + i)) out_latch[i] <= wval;
                        for (int unsigned i = 0; i < SCRATCH_SIZE; i++)
                            if (do_store && iaddr == ADDR_WIDTH'(SCR_BASE + i)) scratch[i] <= wval;
                        case (opcode)
                            OP_IEN:  ien <= d;
                            OP_OEN:  oen <= d;
                            OP_JMP: begin
                                jmp_o <= 1'b1;
                                pc    <= iaddr;
                                if (sp == SPW'(STACK_DEPTH)) begin
                                    stack_err <= 1'b1;
                                end else begin
                                    stack[sp] <= pc_inc;
                                    sp        <= sp + SPW'(1);
                                end
                            end
                            OP_RTN: begin
                                rtn_o <= 1'b1;
                                if (sp == '0) begin
                                    stack_err <= 1'b1;
                                end else begin
                                    pc   <= stack[sp - SPW'(1)];
                                    sp   <= sp - SPW'(1);
                                    skip <= 1'b1;
                                end
                            end
                            OP_SKZ:  if (!rr) skip <= 1'b1;
                            OP_NOPO: flag_o <= 1'b1;
                            OP_NOPF: flag_f <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc14500_seq_core.sv
// Directed bench for mc14500_seq_core: small programs in a synchronous ROM model,
// outputs checked at fixed instruction boundaries against hand-computed values.
module tb_mc14500_seq_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [4:0] input_pins = '0;
    logic [4:0] output_pins;
    logic       flag_o, flag_f, jmp_o, rtn_o, stack_err, rr_out;
    logic [11:0] rom [256];
    int errors = 0;
    int checks = 0;

    mc14500_seq_core_if #(.ADDR_WIDTH(8)) bus ();

    mc14500_seq_core #(
        .ADDR_WIDTH(8), .INPUT_SIZE(5), .OUTPUT_SIZE(5), .SCRATCH_SIZE(16), .STACK_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .prog(bus.master),
        .input_pins(input_pins), .output_pins(output_pins),
        .flag_o(flag_o), .flag_f(flag_f), .jmp_o(jmp_o), .rtn_o(rtn_o),
        .stack_err(stack_err), .rr_out(rr_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.prog_data <= rom[bus.prog_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset, stop the core and blank the ROM to NOPF.
    task automatic prep();
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    endtask

    // Release reset with the given pins, let them synchronise, then start at a negedge.
    task automatic go(input logic [4:0] pins);
        input_pins = pins;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run = 1'b1;
    endtask

    initial begin
        // reset state
        prep();
        rom[0] = 12'h100; rom[1] = 12'h805;
        input_pins = 5'b00001;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(output_pins), 32'h0);
        chk("rst_rr", 32'(rr_out), 32'h0);
        chk("rst_pa", 32'(bus.prog_addr), 32'h0);
        chk("rst_flags", 32'({flag_o, flag_f, jmp_o, rtn_o, stack_err}), 32'h0);

        // LD 0 / STO 5, then stop at the next boundary and resume
        go(5'b00001);
        edges(3);
        chk("ld_rr", 32'(rr_out), 32'h1);
        chk("ld_pa", 32'(bus.prog_addr), 32'h1);
        edges(2);
        chk("sto_out", 32'(output_pins), 32'h01);
        chk("sto_pa", 32'(bus.prog_addr), 32'h2);
        run = 1'b0;
        edges(2);
        chk("nopf_flag", 32'(flag_f), 32'h1);
        chk("stop_pa", 32'(bus.prog_addr), 32'h3);
        edges(1);
        chk("nopf_pulse_end", 32'(flag_f), 32'h0);
        edges(4);
        chk("idle_hold_pa", 32'(bus.prog_addr), 32'h3);
        run = 1'b1;
        edges(3);
        chk("resume_pa", 32'(bus.prog_addr), 32'h4);

        // OEN / IEN gating and logic ops, pin1=1, pin0=0
        prep();
        rom[0]  = 12'hB00; rom[1]  = 12'h101; rom[2]  = 12'h805; rom[3]  = 12'hB01;
        rom[4]  = 12'h805; rom[5]  = 12'hA00; rom[6]  = 12'h101; rom[7]  = 12'h906;
        rom[8]  = 12'hA01; rom[9]  = 12'h106; rom[10] = 12'h705; rom[11] = 12'h405;
        rom[12] = 12'h60A; rom[13] = 12'h9FF;
        go(5'b00010);
        edges(5);  chk("oen_ld_rr", 32'(rr_out), 32'h1);
        edges(2);  chk("oen_off_out", 32'(output_pins), 32'h00);
        edges(4);  chk("oen_on_out", 32'(output_pins), 32'h01);
        edges(4);  chk("ien_off_rr", 32'(rr_out), 32'h0);
        edges(2);  chk("stoc_out", 32'(output_pins), 32'h03);
        edges(4);  chk("ld_readback_rr", 32'(rr_out), 32'h1);
        edges(2);  chk("xnor_rr", 32'(rr_out), 32'h1);
        edges(2);  chk("andc_rr", 32'(rr_out), 32'h0);
        edges(2);  chk("orc_scratch_rr", 32'(rr_out), 32'h1);
        edges(2);  chk("stoc_rraddr_rr", 32'(rr_out), 32'h0);

        // SKZ: taken with RR=0, not taken with RR=1
        prep();
        rom[0] = 12'h200; rom[1] = 12'hE00; rom[2] = 12'h100; rom[3] = 12'h905;
        rom[4] = 12'h100; rom[5] = 12'hE00; rom[6] = 12'h200;
        go(5'b00001);
        edges(3);  chk("skz_ldc_rr", 32'(rr_out), 32'h0);
        edges(4);  chk("skz_skip_rr", 32'(rr_out), 32'h0);
        chk("skz_skip_pa", 32'(bus.prog_addr), 32'h3);
        edges(2);  chk("skz_next_out", 32'(output_pins), 32'h01);
        edges(2);  chk("skz_ld_rr", 32'(rr_out), 32'h1);
        edges(4);  chk("skz_notaken_rr", 32'(rr_out), 32'h0);

        // JMP 0x10 from 3, RTN skips 4 and executes 5
        prep();
        rom[0] = 12'h000; rom[1] = 12'h000; rom[2] = 12'h000; rom[3] = 12'hC10;
        rom[4] = 12'h200; rom[5] = 12'h805; rom[16] = 12'h601; rom[17] = 12'hD00;
        go(5'b00001);
        edges(3);  chk("nopo_flag", 32'(flag_o), 32'h1);
        edges(6);  chk("jmp_pulse", 32'(jmp_o), 32'h1);
        chk("jmp_pa", 32'(bus.prog_addr), 32'h10);
        edges(2);  chk("sub_orc_rr", 32'(rr_out), 32'h1);
        edges(2);  chk("rtn_pulse", 32'(rtn_o), 32'h1);
        chk("rtn_pa", 32'(bus.prog_addr), 32'h4);
        edges(1);  chk("rtn_pulse_end", 32'(rtn_o), 32'h0);
        edges(1);  chk("rtn_skip_pa", 32'(bus.prog_addr), 32'h5);
        chk("rtn_skip_rr", 32'(rr_out), 32'h1);
        edges(2);  chk("rtn_next_out", 32'(output_pins), 32'h01);

        // Five nested JMPs overflow the 4-deep stack; RTN returns to the 4th push
        prep();
        rom[0] = 12'hC01; rom[1] = 12'hC02; rom[2] = 12'hC03; rom[3] = 12'hC04;
        rom[4] = 12'hC05; rom[5] = 12'hD00;
        go(5'b00000);
        edges(9);  chk("push4_err", 32'(stack_err), 32'h0);
        chk("push4_pa", 32'(bus.prog_addr), 32'h4);
        edges(2);  chk("push5_err", 32'(stack_err), 32'h1);
        chk("push5_pa", 32'(bus.prog_addr), 32'h5);
        edges(2);  chk("ovf_rtn_pa", 32'(bus.prog_addr), 32'h4);
        chk("err_sticky", 32'(stack_err), 32'h1);

        // RTN on empty stack: PC+1, no skip
        prep();
        rom[0] = 12'hD00; rom[1] = 12'h000;
        go(5'b00000);
        edges(3);  chk("empty_rtn_pa", 32'(bus.prog_addr), 32'h1);
        chk("empty_rtn_err", 32'(stack_err), 32'h1);
        edges(2);  chk("empty_rtn_noskip", 32'(flag_o), 32'h1);

        // PC wrap at 0xFF, then reset mid-EXEC
        prep();
        rom[0] = 12'h100; rom[1] = 12'h805; rom[2] = 12'hCFF; rom[255] = 12'h000;
        go(5'b00001);
        edges(5);  chk("wrap_pre_out", 32'(output_pins), 32'h01);
        edges(2);  chk("wrap_jmp_pa", 32'(bus.prog_addr), 32'hFF);
        edges(2);  chk("wrap_flag", 32'(flag_o), 32'h1);
        chk("wrap_pa", 32'(bus.prog_addr), 32'h0);
        edges(1);
        reset = 1'b0;
        #1;
        chk("arst_out", 32'(output_pins), 32'h0);
        chk("arst_rr", 32'(rr_out), 32'h0);
        chk("arst_pa", 32'(bus.prog_addr), 32'h0);
        chk("arst_flags", 32'({flag_o, flag_f, jmp_o, rtn_o, stack_err}), 32'h0);
        edges(2);
        chk("arst_hold_rr", 32'(rr_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
